// File: rtl/multiaddr_fork_decode_pkg.sv
// rtl/multiaddr_fork_decode_pkg.sv - FSM state type and single-rule decode helper.
package multiaddr_fork_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FORK,
    ERROR
  } fork_state_e;

  // Callers zero-extend narrower addresses; the extra high bits always match.
  localparam int unsigned MaxAddrWidth = 64;
  typedef logic [MaxAddrWidth-1:0] wide_addr_t;

  typedef struct packed {
    logic       match;
    wide_addr_t addr;
    wide_addr_t mask;
  } rule_decode_t;

  function automatic rule_decode_t decode_rule(
    input wide_addr_t req_addr,
    input wide_addr_t req_mask,
    input wide_addr_t rule_addr,
    input wide_addr_t rule_mask
  );
    rule_decode_t res;
    res.match = &(req_mask | rule_mask | ~(req_addr ^ rule_addr));
    res.addr  = (~req_mask & req_addr) | (req_mask & rule_addr);
    res.mask  = req_mask & rule_mask;
    return res;
  endfunction

endpackage

// File: rtl/multiaddr_fork_decode_decode.sv
// rtl/multiaddr_fork_decode_decode.sv - combinational multi-address decoder (multiaddr_decode).
module multiaddr_decode
  import multiaddr_fork_pkg::*;
#(
  parameter int unsigned NoIndices = 32'd1,
  parameter int unsigned NoRules   = 32'd1,
  parameter type addr_t = logic,
  parameter type rule_t = struct packed {int unsigned idx; addr_t addr; addr_t mask;}
) (
  input  rule_t [NoRules-1:0]   addr_map_i,
  input  addr_t                 addr_i,
  input  addr_t                 mask_i,
  output logic  [NoIndices-1:0] select_o,
  output addr_t [NoIndices-1:0] addr_o,
  output addr_t [NoIndices-1:0] mask_o
);

  localparam int unsigned AW = $bits(addr_t);

  // Later rules overwrite earlier ones, so the highest matching rule per idx wins.
  always_comb begin
    rule_decode_t dec_hi_unused;
    dec_hi_unused = '0;
    select_o      = '0;
    addr_o        = '0;
    mask_o        = '0;
    for (int unsigned r = 0; r < NoRules; r++) begin
      dec_hi_unused = decode_rule(wide_addr_t'(addr_i), wide_addr_t'(mask_i),
                                  wide_addr_t'(addr_map_i[r].addr),
                                  wide_addr_t'(addr_map_i[r].mask));
      for (int unsigned k = 0; k < NoIndices; k++) begin
        if (dec_hi_unused.match && (addr_map_i[r].idx == k)) begin
          select_o[k] = 1'b1;
          addr_o[k]   = dec_hi_unused.addr[AW-1:0];
          mask_o[k]   = dec_hi_unused.mask[AW-1:0];
        end
      end
    end
  end

endmodule

// File: rtl/multiaddr_fork_decode.sv
// rtl/multiaddr_fork_decode.sv - registered multicast fork over a rule-map decode.
// Optional MULTIADDR_FORK_DECODE_BYPASS_EN: accept a new request on the last handshake cycle.
module multiaddr_fork_decode
  import multiaddr_fork_pkg::*;
#(
  parameter int unsigned NoIndices = 32'd1,
  parameter int unsigned NoRules   = 32'd1,
  parameter type addr_t    = logic,
  parameter type payload_t = logic,
  parameter type rule_t    = struct packed {int unsigned idx; addr_t addr; addr_t mask;}
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  rule_t [NoRules-1:0]   addr_map_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  addr_t                 req_addr_i,
  input  addr_t                 req_mask_i,
  input  payload_t              req_data_i,
  output logic  [NoIndices-1:0] mst_valid_o,
  input  logic  [NoIndices-1:0] mst_ready_i,
  output addr_t [NoIndices-1:0] mst_addr_o,
  output addr_t [NoIndices-1:0] mst_mask_o,
  output payload_t              mst_data_o,
  output logic                  err_valid_o,
  input  logic                  err_ready_i,
  output logic                  busy_o
);

  fork_state_e           state_q;
  logic  [NoIndices-1:0] pending_q, pending_d;
  addr_t [NoIndices-1:0] addr_q, mask_q;
  payload_t              data_q;

  logic  [NoIndices-1:0] dec_select;
  addr_t [NoIndices-1:0] dec_addr, dec_mask;
  logic                  req_accept;

  multiaddr_decode #(
    .NoIndices(NoIndices),
    .NoRules  (NoRules),
    .addr_t   (addr_t),
    .rule_t   (rule_t)
  ) i_decode (
    .addr_map_i(addr_map_i),
    .addr_i    (req_addr_i),
    .mask_i    (req_mask_i),
    .select_o  (dec_select),
    .addr_o    (dec_addr),
    .mask_o    (dec_mask)
  );

  assign pending_d  = pending_q & ~mst_ready_i;
  assign req_accept = req_valid_i & req_ready_o;

  always_comb begin
    req_ready_o = 1'b0;
    case (state_q)
      IDLE:    req_ready_o = 1'b1;
`ifdef MULTIADDR_FORK_DECODE_BYPASS_EN
      FORK:    req_ready_o = (pending_d == '0);
      ERROR:   req_ready_o = err_ready_i;
`endif
      default: req_ready_o = 1'b0;
    endcase
    if (rst_i) req_ready_o = 1'b0;
  end

  // An accept always reloads everything; with bypass it can land while FORK/ERROR retires.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      pending_q <= '0;
      addr_q    <= '0;
      mask_q    <= '0;
      data_q    <= '0;
    end else if (req_accept) begin
      pending_q <= dec_select;
      data_q    <= req_data_i;
      state_q   <= (dec_select != '0) ? FORK : ERROR;
      for (int unsigned k = 0; k < NoIndices; k++) begin
        if (dec_select[k]) begin
          addr_q[k] <= dec_addr[k];
          mask_q[k] <= dec_mask[k];
        end
      end
    end else begin
      case (state_q)
        FORK: begin
          pending_q <= pending_d;
          if (pending_d == '0) state_q <= IDLE;
        end
        ERROR: if (err_ready_i) state_q <= IDLE;
        default: ;
      endcase
    end
  end

  assign mst_valid_o = rst_i ? '0 : pending_q;
  assign err_valid_o = ~rst_i & (state_q == ERROR);
  assign busy_o      = ~rst_i & (state_q != IDLE);
  assign mst_addr_o  = addr_q;
  assign mst_mask_o  = mask_q;
  assign mst_data_o  = data_q;

endmodule

// File: tb/tb_multiaddr_fork_decode.sv
// tb/tb_multiaddr_fork_decode.sv - directed bench with per-cycle behavioural model.
module tb_multiaddr_fork_decode;

  typedef logic [7:0] addr_t;
  typedef logic [7:0] payload_t;
  typedef struct packed {
    int unsigned idx;
    addr_t       addr;
    addr_t       mask;
  } rule_t;

  localparam int unsigned NI = 3;
  localparam int unsigned NR = 3;
`ifdef MULTIADDR_FORK_DECODE_BYPASS_EN
  localparam bit Bypass = 1'b1;
`else
  localparam bit Bypass = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               rst;
  rule_t [NR-1:0]     addr_map;
  logic               req_valid, req_ready;
  addr_t              req_addr, req_mask;
  payload_t           req_data;
  logic  [NI-1:0]     mst_valid, mst_ready;
  addr_t [NI-1:0]     mst_addr, mst_mask;
  payload_t           mst_data;
  logic               err_valid, err_ready, busy;

  int errors  = 0;
  int checks  = 0;
  int acc_cnt = 0;

  always #5 clk = ~clk;

  multiaddr_fork_decode #(
    .NoIndices(NI),
    .NoRules  (NR),
    .addr_t   (addr_t),
    .payload_t(payload_t),
    .rule_t   (rule_t)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .addr_map_i (addr_map),
    .req_valid_i(req_valid),
    .req_ready_o(req_ready),
    .req_addr_i (req_addr),
    .req_mask_i (req_mask),
    .req_data_i (req_data),
    .mst_valid_o(mst_valid),
    .mst_ready_i(mst_ready),
    .mst_addr_o (mst_addr),
    .mst_mask_o (mst_mask),
    .mst_data_o (mst_data),
    .err_valid_o(err_valid),
    .err_ready_i(err_ready),
    .busy_o     (busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model state: outstanding channels, pending error, and the captured request.
  logic [NI-1:0] m_pend = '0;
  logic          m_err  = 1'b0;
  addr_t         m_addr[NI];
  addr_t         m_mask[NI];
  payload_t      m_data;

  logic [NI-1:0] d_sel;
  addr_t         d_a[NI];
  addr_t         d_m[NI];

  always_comb begin
    d_sel = '0;
    for (int k = 0; k < NI; k++) begin
      d_a[k] = '0;
      d_m[k] = '0;
    end
    for (int i = 0; i < NR; i++) begin
      if (((req_addr ^ addr_map[i].addr) & ~(req_mask | addr_map[i].mask)) == 8'h00) begin
        d_sel[addr_map[i].idx[1:0]] = 1'b1;
        d_a[addr_map[i].idx[1:0]]   = (req_addr & ~req_mask) | (addr_map[i].addr & req_mask);
        d_m[addr_map[i].idx[1:0]]   = req_mask & addr_map[i].mask;
      end
    end
  end

  function automatic logic model_ready();
    return ((m_pend == '0) && !m_err) ||
           (Bypass && (((m_pend != '0) && ((m_pend & ~mst_ready) == '0)) ||
                       (m_err && err_ready)));
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_pend <= '0;
      m_err  <= 1'b0;
    end else if (req_valid && model_ready()) begin
      m_pend <= d_sel;
      m_err  <= (d_sel == '0);
      m_data <= req_data;
      for (int k = 0; k < NI; k++) begin
        if (d_sel[k]) begin
          m_addr[k] <= d_a[k];
          m_mask[k] <= d_m[k];
        end
      end
    end else begin
      m_pend <= m_pend & ~mst_ready;
      if (err_ready) m_err <= 1'b0;
    end
    if (!rst && req_valid && req_ready) acc_cnt <= acc_cnt + 1;
  end

  always @(negedge clk) begin
    if (rst) begin
      chk("rst_req_ready", 32'(req_ready), 32'd0);
      chk("rst_mst_valid", 32'(mst_valid), 32'd0);
      chk("rst_err_valid", 32'(err_valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
    end else begin
      chk("m_req_ready", 32'(req_ready), 32'(model_ready()));
      chk("m_mst_valid", 32'(mst_valid), 32'(m_pend));
      chk("m_err_valid", 32'(err_valid), 32'(m_err));
      chk("m_busy", 32'(busy), 32'((m_pend != '0) || m_err));
      if (m_pend != '0) chk("m_data", 32'(mst_data), 32'(m_data));
      for (int k = 0; k < NI; k++) begin
        if (m_pend[k]) begin
          chk("m_addr", 32'(mst_addr[k]), 32'(m_addr[k]));
          chk("m_mask", 32'(mst_mask[k]), 32'(m_mask[k]));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int base;
    int n;
    rst       = 1'b1;
    req_valid = 1'b0;
    req_addr  = '0;
    req_mask  = '0;
    req_data  = '0;
    mst_ready = '0;
    err_ready = 1'b0;
    addr_map[0] = '{idx: 0, addr: 8'h00, mask: 8'h0F};
    addr_map[1] = '{idx: 1, addr: 8'h10, mask: 8'h0F};
    addr_map[2] = '{idx: 2, addr: 8'h80, mask: 8'h7F};

    @(negedge clk);
    chk("reset_ready", 32'(req_ready), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    tick();
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("post_reset_ready", 32'(req_ready), 32'd1);
    tick();

    // Single match
    req_valid = 1'b1; req_addr = 8'h05; req_mask = 8'h00; req_data = 8'hA1;
    mst_ready = 3'b111;
    @(negedge clk);
    chk("t1_ready", 32'(req_ready), 32'd1);
    tick();
    req_valid = 1'b0;
    @(negedge clk);
    chk("t1_valid", 32'(mst_valid), 32'b001);
    chk("t1_addr0", 32'(mst_addr[0]), 32'h05);
    chk("t1_mask0", 32'(mst_mask[0]), 32'h00);
    chk("t1_data", 32'(mst_data), 32'hA1);
    tick();
    @(negedge clk);
    chk("t1_idle_ready", 32'(req_ready), 32'd1);
    chk("t1_idle_valid", 32'(mst_valid), 32'd0);
    tick();

    // Partial fork, channel 1 stalled
    req_valid = 1'b1; req_addr = 8'h00; req_mask = 8'h1F; req_data = 8'hB2;
    mst_ready = 3'b101;
    tick();
    req_valid = 1'b0;
    @(negedge clk);
    chk("t2_valid", 32'(mst_valid), 32'b011);
    chk("t2_addr0", 32'(mst_addr[0]), 32'h00);
    chk("t2_mask0", 32'(mst_mask[0]), 32'h0F);
    chk("t2_addr1", 32'(mst_addr[1]), 32'h10);
    chk("t2_mask1", 32'(mst_mask[1]), 32'h0F);
    chk("t2_ready_a", 32'(req_ready), 32'd0);
    for (int c = 0; c < 2; c++) begin
      tick();
      @(negedge clk);
      chk("t2_hold_valid", 32'(mst_valid), 32'b010);
      chk("t2_hold_data", 32'(mst_data), 32'hB2);
      chk("t2_hold_ready", 32'(req_ready), 32'd0);
    end
    tick();
    mst_ready = 3'b111;
    @(negedge clk);
    chk("t2_last_valid", 32'(mst_valid), 32'b010);
    chk("t2_last_ready", 32'(req_ready), Bypass ? 32'd1 : 32'd0);
    tick();
    @(negedge clk);
    chk("t2_done_ready", 32'(req_ready), 32'd1);
    tick();

    // No match, error held
    req_valid = 1'b1; req_addr = 8'h40; req_mask = 8'h00; req_data = 8'h33;
    err_ready = 1'b0;
    tick();
    req_valid = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk("t3_err", 32'(err_valid), 32'd1);
      chk("t3_valid", 32'(mst_valid), 32'd0);
      tick();
    end
    err_ready = 1'b1;
    @(negedge clk);
    chk("t3_err_last", 32'(err_valid), 32'd1);
    tick();
    @(negedge clk);
    chk("t3_err_gone", 32'(err_valid), 32'd0);
    chk("t3_idle_ready", 32'(req_ready), 32'd1);
    tick();
    err_ready = 1'b0;

    // Reset mid-fork
    req_valid = 1'b1; req_addr = 8'h00; req_mask = 8'h1F; req_data = 8'h44;
    mst_ready = 3'b101;
    tick();
    req_valid = 1'b0;
    @(negedge clk);
    chk("t4_valid", 32'(mst_valid), 32'b011);
    tick();
    rst = 1'b1;
    @(negedge clk);
    chk("t4_rst_valid", 32'(mst_valid), 32'd0);
    chk("t4_rst_busy", 32'(busy), 32'd0);
    tick();
    rst = 1'b0;
    mst_ready = 3'b000;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk("t4_after_ready", 32'(req_ready), 32'd1);
      chk("t4_after_valid", 32'(mst_valid), 32'd0);
      tick();
    end

    // Map change while in flight
    req_valid = 1'b1; req_addr = 8'h05; req_mask = 8'h00; req_data = 8'h55;
    tick();
    req_valid = 1'b0;
    addr_map[0].addr = 8'h20;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk("t5_valid", 32'(mst_valid), 32'b001);
      chk("t5_addr0", 32'(mst_addr[0]), 32'h05);
      tick();
    end
    mst_ready = 3'b111;
    tick();
    addr_map[0].addr = 8'h00;
    @(negedge clk);
    chk("t5_done_valid", 32'(mst_valid), 32'd0);
    tick();

    // Back-to-back throughput
    base = acc_cnt;
    for (int c = 0; c < 8; c++) begin
      n = acc_cnt - base;
      req_valid = (n < 4);
      req_addr  = 8'(n + 1);
      req_mask  = 8'h00;
      req_data  = 8'(32'hC0 + n);
      tick();
      if (c == 3) chk("t6_accepts_4cyc", 32'(acc_cnt - base), Bypass ? 32'd4 : 32'd2);
    end
    req_valid = 1'b0;
    chk("t6_accepts_8cyc", 32'(acc_cnt - base), 32'd4);
    tick();
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
